// File: rtl/seg_scan_if.sv
// seg_scan_if: digit write port and commit strobe for seg_scan_ctrl.
// AW is the digit address width (clog2 of the digit count).
interface seg_scan_if #(
  parameter int AW = 2
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          commit;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output commit,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  commit,
    output wr_ready
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-cathode
// 7-segment display. Digit values are written into a shadow buffer and
// copied to the active buffer only at a frame boundary after a commit,
// so multi-digit updates never tear. Each digit slot is a blanking gap
// of BLANK_CYC cycles followed by PRESCALE cycles of drive.
// Optional feature macro: SEG_SCAN_HEX_EN (values 10-15 shown as hex
// glyphs; blank when undefined).
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int PRESCALE  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  seg_scan_if.slave         wr,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_sel,
  output logic              frame_done
);

  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CMAX = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [IW-1:0] IDX_ZERO = IW'(0);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  // 4-bit value to active-high {g,f,e,d,c,b,a} segment pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0:    seg_decode = 7'b0111111;
      4'h1:    seg_decode = 7'b0000110;
      4'h2:    seg_decode = 7'b1011011;
      4'h3:    seg_decode = 7'b1001111;
      4'h4:    seg_decode = 7'b1100110;
      4'h5:    seg_decode = 7'b1101101;
      4'h6:    seg_decode = 7'b1111101;
      4'h7:    seg_decode = 7'b0000111;
      4'h8:    seg_decode = 7'b1111111;
      4'h9:    seg_decode = 7'b1101111;
`ifdef SEG_SCAN_HEX_EN
      4'hA:    seg_decode = 7'b1110111;
      4'hB:    seg_decode = 7'b1111100;
      4'hC:    seg_decode = 7'b0111001;
      4'hD:    seg_decode = 7'b1011110;
      4'hE:    seg_decode = 7'b1111001;
      4'hF:    seg_decode = 7'b1110001;
`endif
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  state_t                 state_r, state_nxt_s;
  logic [CW-1:0]          cnt_r, cnt_nxt_s;
  logic [IW-1:0]          idx_r, idx_nxt_s;
  logic                   pending_r;
  logic [DIGITS-1:0][3:0] shadow_r;
  logic [DIGITS-1:0][3:0] active_r;
  logic                   commit_now_s;
  logic                   fd_nxt_s;
  logic                   wr_fire_s;
  logic [3:0]             act_digit_s;
  logic [6:0]             seg_nxt_s;
  logic [DIGITS-1:0]      dig_nxt_s;

  // Writes are only taken while no commit is waiting, so the shadow
  // snapshot cannot change between commit request and frame boundary.
  assign wr.wr_ready = ~pending_r;
  assign wr_fire_s   = wr.wr_valid & ~pending_r;

  // Scan sequencing: next state, slot counter, digit index, boundary events.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    idx_nxt_s    = idx_r;
    fd_nxt_s     = 1'b0;
    commit_now_s = 1'b0;
    if (!enable) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = CNT_ZERO;
      idx_nxt_s   = IDX_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_BLANK;
          cnt_nxt_s   = CNT_ZERO;
          idx_nxt_s   = IDX_ZERO;
        end
        ST_BLANK: begin
          if (cnt_r == BLK_LAST) begin
            state_nxt_s = ST_DRIVE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_DRIVE: begin
          if (cnt_r == PRE_LAST) begin
            state_nxt_s = ST_BLANK;
            cnt_nxt_s   = CNT_ZERO;
            if (idx_r == IDX_LAST) begin
              idx_nxt_s    = IDX_ZERO;
              fd_nxt_s     = 1'b1;
              commit_now_s = pending_r;
            end else begin
              idx_nxt_s = idx_r + IDX_ONE;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
          idx_nxt_s   = IDX_ZERO;
        end
      endcase
    end
  end

  // Output patterns for the state being entered, so registered outputs
  // line up with the state register.
  always_comb begin
    act_digit_s = 4'h0;
    dig_nxt_s   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      act_digit_s  = act_digit_s | ((idx_nxt_s == IW'(i)) ? active_r[i] : 4'h0);
      dig_nxt_s[i] = (state_nxt_s == ST_DRIVE) && (idx_nxt_s == IW'(i));
    end
    seg_nxt_s = (state_nxt_s == ST_DRIVE) ? seg_decode(act_digit_s) : 7'b0000000;
  end

  // FSM state, counters and registered display outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      idx_r      <= IDX_ZERO;
      seg        <= 7'b0000000;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      idx_r      <= idx_nxt_s;
      seg        <= seg_nxt_s;
      dig_sel    <= dig_nxt_s;
      frame_done <= fd_nxt_s;
    end
  end

  // Shadow writes, commit request flag and frame-boundary copy to active.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_r <= 1'b0;
      shadow_r  <= '0;
      active_r  <= '0;
    end else begin
      // Out-of-range addresses match no digit and are dropped.
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_fire_s && (wr.wr_addr == IW'(i))) begin
          shadow_r[i] <= wr.wr_data;
        end
      end
      if (commit_now_s) begin
        active_r  <= shadow_r;
        pending_r <= 1'b0;
      end else if (wr.commit && !pending_r) begin
        pending_r <= 1'b1;
      end
    end
  end

endmodule
